// File: rtl/color_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module   : color_sequencer_pkg
// Brief    : Shared widths, reset colour, step-FSM encoding and counter sizing.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package color_sequencer_pkg;

    localparam int c_COLOR_W = 3;
    localparam int c_SQ_W    = 4;

    localparam logic [c_COLOR_W-1:0] c_COLOR_RESET = 3'b001;
    localparam logic [c_COLOR_W-1:0] c_COLOR_ONE   = 3'b001;

    typedef logic [1:0] step_state_t;

    localparam step_state_t c_ST_IDLE   = 2'd0;
    localparam step_state_t c_ST_PRESS  = 2'd1;
    localparam step_state_t c_ST_DELAY  = 2'd2;
    localparam step_state_t c_ST_REPEAT = 2'd3;

    // Bits needed for a counter that must hold every value 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/color_sequencer_btn_debounce.sv
//------------------------------------------------------------------------------
// Module   : color_sequencer_btn_debounce
// Brief    : Two-flop synchroniser followed by a stable-level debounce counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module color_sequencer_btn_debounce
    import color_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_level_next
);

    localparam int                 c_CNT_W    = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [1:0]         r_sync;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_differs;
    logic               w_accept;

    assign w_differs = r_sync[1] != r_level;
    assign w_accept  = w_differs && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            // Any agreeing cycle restarts the stability window.
            if (!w_differs || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            if (w_accept) begin
                r_level <= r_sync[1];
            end
        end
    end

    assign o_level      = r_level;
    assign o_level_next = w_accept ? r_sync[1] : r_level;

endmodule

`default_nettype wire

// File: rtl/color_sequencer.sv
//------------------------------------------------------------------------------
// Module   : color_sequencer
// Brief    : Button-driven colour stepper with auto-repeat and idle demo mode.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module color_sequencer
    import color_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter int IDLE_TIMEOUT    = 256,
    parameter int DEMO_PERIOD     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           push_buttons,
    input  logic [c_SQ_W-1:0]    dip_switch,
    input  logic                 demo_en,
    output logic [c_COLOR_W-1:0] color,
    output logic [c_SQ_W-1:0]    squares,
    output logic                 demo_active,
    output logic                 step_pulse
);

    localparam int c_HOLD_MAX = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
    localparam int c_HOLD_W   = cnt_width(c_HOLD_MAX);
    localparam int c_IDLE_W   = cnt_width(IDLE_TIMEOUT);
    localparam int c_DEMO_W   = cnt_width(DEMO_PERIOD - 1);

    localparam logic [c_HOLD_W-1:0] c_DELAY_LAST  = c_HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [c_HOLD_W-1:0] c_PERIOD_LAST = c_HOLD_W'(REPEAT_PERIOD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE    = c_HOLD_W'(1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX    = c_IDLE_W'(IDLE_TIMEOUT);
    localparam logic [c_IDLE_W-1:0] c_IDLE_ONE    = c_IDLE_W'(1);
    localparam logic [c_DEMO_W-1:0] c_DEMO_LAST   = c_DEMO_W'(DEMO_PERIOD - 1);
    localparam logic [c_DEMO_W-1:0] c_DEMO_ONE    = c_DEMO_W'(1);

    logic [1:0]           w_db;
    logic [1:0]           w_db_next;
    logic                 w_req;
    logic                 w_req_inc;

    logic [c_SQ_W-1:0]    r_dip_sync1;
    logic [c_SQ_W-1:0]    r_dip_sync2;
    logic [c_SQ_W-1:0]    r_squares;

    step_state_t          r_state;
    step_state_t          w_state_next;
    logic                 r_dir_inc;
    logic                 w_dir_inc_next;
    logic [c_HOLD_W-1:0]  r_hold;
    logic [c_HOLD_W-1:0]  w_hold_next;
    logic                 w_btn_step;

    logic [c_IDLE_W-1:0]  r_idle;
    logic                 w_idle_clr;
    logic                 r_demo_active;
    logic [c_DEMO_W-1:0]  r_demo_cnt;
    logic                 w_demo_step;

    logic [c_COLOR_W-1:0] r_color;
    logic                 r_step_pulse;

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        color_sequencer_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_raw        (push_buttons[gi]),
            .o_level      (w_db[gi]),
            .o_level_next (w_db_next[gi])
        );
    end

    // The step FSM follows the debounced level being registered this edge,
    // so the press is acted on in the same cycle the debouncer accepts it.
    assign w_req     = |w_db_next;
    assign w_req_inc = w_db_next[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dip_sync1 <= '0;
            r_dip_sync2 <= '0;
            r_squares   <= '0;
        end else begin
            r_dip_sync1 <= dip_switch;
            r_dip_sync2 <= r_dip_sync1;
            r_squares   <= r_dip_sync2;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_dir_inc_next = r_dir_inc;
        w_hold_next    = '0;
        w_btn_step     = 1'b0;
        if (r_state == c_ST_IDLE) begin
            if (w_req) begin
                w_state_next   = c_ST_PRESS;
                w_dir_inc_next = w_req_inc;
            end
        end else if (!w_req) begin
            w_state_next = c_ST_IDLE;
        end else if (w_req_inc != r_dir_inc) begin
            // Owning button changed while held: restart as a fresh press.
            w_state_next   = c_ST_PRESS;
            w_dir_inc_next = w_req_inc;
        end else if (r_state == c_ST_PRESS) begin
            w_btn_step   = 1'b1;
            w_state_next = c_ST_DELAY;
        end else if (r_state == c_ST_DELAY) begin
            if (r_hold == c_DELAY_LAST) begin
                w_btn_step   = 1'b1;
                w_state_next = c_ST_REPEAT;
            end else begin
                w_hold_next = r_hold + c_HOLD_ONE;
            end
        end else begin
            if (r_hold == c_PERIOD_LAST) begin
                w_btn_step = 1'b1;
            end else begin
                w_hold_next = r_hold + c_HOLD_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_dir_inc <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_dir_inc <= w_dir_inc_next;
            r_hold    <= w_hold_next;
        end
    end

    assign w_idle_clr  = !demo_en || (|w_db) || w_req || (r_state != c_ST_IDLE);
    assign w_demo_step = r_demo_active && demo_en && !w_req && (r_demo_cnt == c_DEMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle        <= '0;
            r_demo_active <= 1'b0;
            r_demo_cnt    <= '0;
        end else begin
            if (w_idle_clr) begin
                r_idle <= '0;
            end else if (r_idle != c_IDLE_MAX) begin
                r_idle <= r_idle + c_IDLE_ONE;
            end

            if (!demo_en || w_req) begin
                r_demo_active <= 1'b0;
            end else if (r_idle == c_IDLE_MAX) begin
                r_demo_active <= 1'b1;
            end

            if (!r_demo_active || !demo_en || w_req || w_demo_step) begin
                r_demo_cnt <= '0;
            end else begin
                r_demo_cnt <= r_demo_cnt + c_DEMO_ONE;
            end
        end
    end

    // Button and demo steps are mutually exclusive: any request ends demo mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_color      <= c_COLOR_RESET;
            r_step_pulse <= 1'b0;
        end else if (w_btn_step) begin
            r_color      <= r_dir_inc ? (r_color + c_COLOR_ONE) : (r_color - c_COLOR_ONE);
            r_step_pulse <= 1'b1;
        end else if (w_demo_step) begin
            r_color      <= r_color + c_COLOR_ONE;
            r_step_pulse <= 1'b1;
        end else begin
            r_step_pulse <= 1'b0;
        end
    end

    assign color       = r_color;
    assign squares     = r_squares;
    assign demo_active = r_demo_active;
    assign step_pulse  = r_step_pulse;

endmodule

`default_nettype wire
